// File: rtl/screen_cmd_engine.sv
// screen_cmd_engine
//   Command execution engine sitting between the host register file and
//   port A of the screen RAM. A command is latched on req (IDLE only); the
//   engine then owns the RAM port (active=1) and performs CLEAR, FILL or a
//   forward byte-sequential COPY at one RAM access per clock. Completion is
//   reported with a one-cycle done pulse and an err flag valid with done.
//
// Optional feature (macro SCREEN_CMD_ABORT_EN):
//   adds input 'abort'; when sampled high in FILL/CP_RD/CP_WAIT/CP_WR the
//   engine goes to FIN with err=1. Undefined by default.
//
// Ports:
//   clk        in   fabric/memory clock (same as screen RAM)
//   rst        in   asynchronous active-high reset
//   abort      in   abort running command (SCREEN_CMD_ABORT_EN only)
//   req        in   command request, accepted only in IDLE
//   cmd        in   8'h00 NOP, 8'h01 CLEAR, 8'h02 FILL, 8'h03 COPY
//   user_addr  in   FILL start / COPY destination
//   src_addr   in   COPY source
//   length     in   FILL/COPY byte count
//   fill_val   in   FILL data byte
//   mem_addr   out  RAM port A address
//   mem_wdata  out  RAM port A write data
//   mem_wren   out  RAM port A write enable
//   mem_rdata  in   RAM port A read data (one clock read latency)
//   active     out  engine owns RAM port A
//   done       out  one-cycle completion pulse
//   err        out  error flag, valid while done=1
module screen_cmd_engine #(
  parameter int          ADDR_W    = 16,
  parameter int          LEN_W     = 16,
  parameter int          CLEAR_LEN = 2400,
  parameter logic [7:0]  CLEAR_VAL = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SCREEN_CMD_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req,
  input  logic [7:0]        cmd,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        fill_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [7:0]        mem_rdata,
  output logic              active,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_FILL  = 8'h02;
  localparam logic [7:0] CMD_COPY  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CP_RD,
    S_CP_WAIT,
    S_CP_WR,
    S_FIN
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   src_q, src_n;
  logic [ADDR_W-1:0]   dst_q, dst_n;
  logic [LEN_W-1:0]    cnt_q, cnt_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          wdata_n;
  logic                wren_n, active_n, done_n, err_n;
  logic                abort_hit;

  // All outputs are registered: the combinational block computes what the
  // port should show in the next cycle. cnt_q holds the number of bytes
  // still to be written, including the one currently on the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      cnt_q     <= cnt_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_wren  <= wren_n;
      active    <= active_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    src_n     = src_q;
    dst_n     = dst_q;
    cnt_n     = cnt_q;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    wren_n    = 1'b0;
    active_n  = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
`ifdef SCREEN_CMD_ABORT_EN
    abort_hit = abort;
`else
    abort_hit = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (req) begin
          case (cmd)
            CMD_NOP: begin
              state_n = S_FIN;
              done_n  = 1'b1;
            end
            CMD_CLEAR: begin
              state_n  = S_FILL;
              addr_n   = '0;
              wdata_n  = CLEAR_VAL;
              cnt_n    = LEN_W'(CLEAR_LEN);
              wren_n   = 1'b1;
              active_n = 1'b1;
            end
            CMD_FILL: begin
              if (length == '0) begin
                state_n = S_FIN;
                done_n  = 1'b1;
              end else begin
                state_n  = S_FILL;
                addr_n   = user_addr;
                wdata_n  = fill_val;
                cnt_n    = length;
                wren_n   = 1'b1;
                active_n = 1'b1;
              end
            end
            CMD_COPY: begin
              if (length == '0) begin
                state_n = S_FIN;
                done_n  = 1'b1;
              end else begin
                state_n  = S_CP_RD;
                addr_n   = src_addr;
                src_n    = src_addr;
                dst_n    = user_addr;
                cnt_n    = length;
                active_n = 1'b1;
              end
            end
            default: begin
              state_n = S_FIN;
              done_n  = 1'b1;
              err_n   = 1'b1;
            end
          endcase
        end
      end

      S_FILL: begin
        if (abort_hit) begin
          state_n = S_FIN;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else if (cnt_q == LEN_W'(1)) begin
          state_n = S_FIN;
          done_n  = 1'b1;
        end else begin
          addr_n   = mem_addr + ADDR_W'(1);
          cnt_n    = cnt_q - LEN_W'(1);
          wren_n   = 1'b1;
          active_n = 1'b1;
        end
      end

      // Address already on the port; RAM registers the read at this edge.
      S_CP_RD: begin
        if (abort_hit) begin
          state_n = S_FIN;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          state_n  = S_CP_WAIT;
          active_n = 1'b1;
        end
      end

      // Read data is valid in this cycle and is captured straight into the
      // write-data register for the following write.
      S_CP_WAIT: begin
        if (abort_hit) begin
          state_n = S_FIN;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          state_n  = S_CP_WR;
          addr_n   = dst_q;
          wdata_n  = mem_rdata;
          wren_n   = 1'b1;
          active_n = 1'b1;
        end
      end

      S_CP_WR: begin
        src_n = src_q + ADDR_W'(1);
        dst_n = dst_q + ADDR_W'(1);
        cnt_n = cnt_q - LEN_W'(1);
        if (abort_hit) begin
          state_n = S_FIN;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else if (cnt_q == LEN_W'(1)) begin
          state_n = S_FIN;
          done_n  = 1'b1;
        end else begin
          state_n  = S_CP_RD;
          addr_n   = src_q + ADDR_W'(1);
          active_n = 1'b1;
        end
      end

      S_FIN: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_screen_cmd_engine.sv
// tb_screen_cmd_engine
//   Self-checking bench for screen_cmd_engine. A synchronous RAM model with
//   one clock read latency is attached to port A; a byte-array reference
//   model applies each command's effect with plain loops, and expected
//   timing (writes, active cycles, done cycle, err) is derived from the
//   command rules. Directed steps are followed by random commands.
module tb_screen_cmd_engine;

  localparam int         ADDR_W    = 16;
  localparam int         LEN_W     = 16;
  localparam int         CLEAR_LEN = 2400;
  localparam logic [7:0] CLEAR_VAL = 8'h20;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] user_addr;
  logic [ADDR_W-1:0] src_addr;
  logic [LEN_W-1:0]  length;
  logic [7:0]        fill_val;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wren;
  logic [7:0]        mem_rdata;
  logic              active;
  logic              done;
  logic              err;
`ifdef SCREEN_CMD_ABORT_EN
  logic              abort;
`endif

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       ramLoad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  screen_cmd_engine #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .CLEAR_LEN (CLEAR_LEN),
    .CLEAR_VAL (CLEAR_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SCREEN_CMD_ABORT_EN
    .abort     (abort),
`endif
    .req       (req),
    .cmd       (cmd),
    .user_addr (user_addr),
    .src_addr  (src_addr),
    .length    (length),
    .fill_val  (fill_val),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata),
    .active    (active),
    .done      (done),
    .err       (err)
  );

  // Screen RAM port A: read-before-write, one clock read latency.
  always @(posedge clk) begin
    if (ramLoad) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMemory(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) bad++;
    checkOutput($sformatf("%s.mem_mismatches", tag), bad, 0);
  endtask

  // Runs one command. holdReq keeps req asserted (with a CLEAR) while busy;
  // rstAfter>0 asserts reset once that many writes have committed;
  // abortAfter>0 raises abort in the cycle of that write (FILL only).
  task automatic applyStimulus(input string tag, input logic [7:0] c, input logic [15:0] ua,
                               input logic [15:0] sa, input logic [15:0] len, input logic [7:0] fv,
                               input bit holdReq, input int rstAfter, input int abortAfter);
    int n, expWrites, expActive, expDone, budget;
    int writes, actives, doneCyc;
    bit expErr, errSeen, stopped;
    logic [15:0] a, b;

    case (c)
      8'h00:        n = 0;
      8'h01:        n = CLEAR_LEN;
      8'h02, 8'h03: n = int'(len);
      default:      n = 0;
    endcase
    expErr = (c > 8'h03);
    if (rstAfter > 0 && rstAfter < n) n = rstAfter;
    if (abortAfter > 0 && abortAfter < n) begin
      n = abortAfter;
      expErr = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if (c == 8'h01) begin
        ref_mem[i] = CLEAR_VAL;
      end else begin
        a = ua + 16'(i);
        b = sa + 16'(i);
        ref_mem[a] = (c == 8'h02) ? fv : ref_mem[b];
      end
    end
    expWrites = n;
    expActive = (c == 8'h03) ? 3 * n : n;
    expDone   = expActive + 1;
    budget    = expDone + 20;

    @(negedge clk);
    cmd = c; user_addr = ua; src_addr = sa; length = len; fill_val = fv; req = 1'b1;
    @(posedge clk);
    #1;
    cmd = 8'($urandom); user_addr = 16'($urandom); src_addr = 16'($urandom);
    length = 16'($urandom); fill_val = 8'($urandom);
    if (holdReq) cmd = 8'h01;
    else req = 1'b0;

    writes = 0; actives = 0; doneCyc = 0; errSeen = 1'b0; stopped = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (mem_wren) writes++;
      if (active) actives++;
      if (done) begin
        doneCyc = cyc;
        errSeen = err;
        req = 1'b0;
        break;
      end
      if (rstAfter > 0 && writes == rstAfter) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput($sformatf("%s.rst_wren", tag), mem_wren, 0);
        checkOutput($sformatf("%s.rst_active", tag), active, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput($sformatf("%s.rst_no_done", tag), done, 0);
        end
        rst = 1'b0;
        stopped = 1'b1;
        break;
      end
`ifdef SCREEN_CMD_ABORT_EN
      if (abortAfter > 0 && writes == abortAfter) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
`endif
    end
    req = 1'b0;

    if (stopped) begin
      checkOutput($sformatf("%s.writes_before_rst", tag), writes, rstAfter);
    end else begin
      checkOutput($sformatf("%s.done_cycle", tag), doneCyc, expDone);
      checkOutput($sformatf("%s.writes", tag), writes, expWrites);
      checkOutput($sformatf("%s.active_cycles", tag), actives, expActive);
      checkOutput($sformatf("%s.err", tag), errSeen, expErr);
      @(negedge clk);
      checkOutput($sformatf("%s.done_one_cycle", tag), done, 0);
      checkOutput($sformatf("%s.idle_active", tag), active, 0);
    end
    checkMemory(tag);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [15:0] rs, rd, rl;
    int          kind;

    rst = 1'b1; req = 1'b0; cmd = '0; user_addr = '0; src_addr = '0;
    length = '0; fill_val = '0; ramLoad = 1'b0;
`ifdef SCREEN_CMD_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    checkOutput("reset.mem_addr", mem_addr, 0);
    checkOutput("reset.mem_wdata", mem_wdata, 0);
    checkOutput("reset.mem_wren", mem_wren, 0);
    checkOutput("reset.active", active, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.err", err, 0);

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 5);
    ramLoad = 1'b1;
    @(negedge clk);
    ramLoad = 1'b0;
    rst = 1'b0;

    applyStimulus("fill4", 8'h02, 16'h0100, 16'h0000, 16'd4, 8'hAA, 0, 0, 0);

    applyStimulus("clear", 8'h01, 16'h1234, 16'h4321, 16'd7, 8'h99, 0, 0, 0);
    checkOutput("clear.last_byte", ram[2399], CLEAR_VAL);
    checkOutput("clear.untouched_2400", ram[2400], ref_mem[2400]);

    applyStimulus("pre0", 8'h02, 16'h0010, 16'h0000, 16'd1, 8'h10, 0, 0, 0);
    applyStimulus("pre1", 8'h02, 16'h0011, 16'h0000, 16'd1, 8'h20, 0, 0, 0);
    applyStimulus("pre2", 8'h02, 16'h0012, 16'h0000, 16'd1, 8'h30, 0, 0, 0);
    applyStimulus("copy3", 8'h03, 16'h0200, 16'h0010, 16'd3, 8'h00, 0, 0, 0);
    checkOutput("copy3.byte2", ram[16'h0202], 8'h30);

    applyStimulus("fill_wrap", 8'h02, 16'hFFFE, 16'h0000, 16'd3, 8'h55, 0, 0, 0);
    checkOutput("fill_wrap.addr0", ram[0], 8'h55);
    applyStimulus("illegal07", 8'h07, 16'h0000, 16'h0000, 16'd5, 8'h00, 0, 0, 0);

    applyStimulus("req_ignored", 8'h02, 16'h0300, 16'h0000, 16'd8, 8'h3C, 1, 0, 0);
    applyStimulus("rst_mid", 8'h02, 16'h0400, 16'h0000, 16'd8, 8'hC3, 0, 3, 0);
    applyStimulus("after_rst", 8'h02, 16'h0400, 16'h0000, 16'd8, 8'h5A, 0, 0, 0);

    applyStimulus("nop", 8'h00, 16'h0000, 16'h0000, 16'd9, 8'h00, 0, 0, 0);
    applyStimulus("fill_len0", 8'h02, 16'h0600, 16'h0000, 16'd0, 8'h11, 0, 0, 0);
    applyStimulus("copy_len0", 8'h03, 16'h0600, 16'h0010, 16'd0, 8'h00, 0, 0, 0);
    applyStimulus("copy_overlap", 8'h03, 16'h0102, 16'h0100, 16'd6, 8'h00, 0, 0, 0);
    applyStimulus("copy_same", 8'h03, 16'h0200, 16'h0200, 16'd3, 8'h00, 0, 0, 0);
    applyStimulus("copy_wrap", 8'h03, 16'h0001, 16'hFFFE, 16'd4, 8'h00, 0, 0, 0);

`ifdef SCREEN_CMD_ABORT_EN
    applyStimulus("abort_fill", 8'h02, 16'h0500, 16'h0000, 16'd6, 8'h77, 0, 0, 2);
`endif

    for (int t = 0; t < 25; t++) begin
      kind = int'($urandom_range(0, 9));
      rs   = 16'($urandom);
      rd   = (kind >= 8) ? rs + 16'($urandom_range(0, 5)) : 16'($urandom);
      rl   = 16'($urandom_range(0, 12));
      if (kind == 0)      rc = 8'h00;
      else if (kind == 1) rc = 8'($urandom_range(4, 255));
      else if (kind < 6)  rc = 8'h02;
      else                rc = 8'h03;
      applyStimulus($sformatf("rand%0d", t), rc, rd, rs, rl, 8'($urandom), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
